// File: rtl/zx_kbd_matrix_tx.sv
// zx_kbd_matrix_tx
// Serial transmitter for the keyboard-matrix switch link (DAT/SK/STB).
// Commands {Y, X, state} enter through a valid/ready port into a small FIFO.
// Each command goes out as 7 address bits {Y,X}, MSB first, clocked by SK.
// The state bit follows and is committed by an STB pulse.
//
// Optional build macro: ZX_KBD_SHADOW_EN
//   When defined, a 128-entry shadow of the switch states is kept.
//   A command that would not change its switch is acknowledged but not sent.
//
// Handshake: a command transfers on a rising CLK edge where CMD_VALID and
// CMD_READY are both high. CMD_READY is registered and equals "FIFO not full".
// It does not depend on CMD_VALID, and no push/pop bypass exists when full.
module zx_kbd_matrix_tx #(
  parameter int DIV        = 4,  // clock cycles per protocol phase, 1..255
  parameter int FIFO_DEPTH = 4   // power of two, >= 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [2:0] CMD_Y,
  input  logic [3:0] CMD_X,
  input  logic       CMD_STATE,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  output logic       BUSY,
  output logic       DAT,
  output logic       SK,
  output logic       STB,
  output logic [2:0] dbg_state
);

  localparam int         AW         = $clog2(FIFO_DEPTH);
  localparam logic [7:0] CNT_RELOAD = 8'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_BIT_LO    = 3'd1,
    S_BIT_HI    = 3'd2,
    S_CMT_SETUP = 3'd3,
    S_CMT_STB   = 3'd4,
    S_CMT_HOLD  = 3'd5
  } state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic [2:0]  idx;
  logic [6:0]  sh_word;
  logic        sh_state;

  // FIFO storage: entry = {Y[2:0], X[3:0], state}
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] wr_ptr_nxt;
  logic [AW:0] rd_ptr_nxt;
  logic        fifo_empty;
  logic        fifo_full_nxt;
  logic        fifo_empty_nxt;
  logic [7:0]  head;
  logic [7:0]  cmd_entry;

  logic        accept;
  logic        push;
  logic        pop;
  logic        fsm_done;
  logic        fsm_active_nxt;

  assign cmd_entry = {CMD_Y, CMD_X, CMD_STATE};
  assign accept    = CMD_VALID && CMD_READY;
  assign head      = mem[rd_ptr[AW-1:0]];
  assign dbg_state = state;

`ifdef ZX_KBD_SHADOW_EN
  // Last committed state per switch; 1 = released
  logic [127:0] shadow;
  logic [6:0]   cmd_idx;

  assign cmd_idx = {CMD_Y, CMD_X};
  // Commands that would not change the switch are acknowledged and dropped
  assign push    = accept && (CMD_STATE != shadow[cmd_idx]);

  // Track the state the receiver will hold once queued commands are sent
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shadow <= '1;
    end else if (push) begin
      shadow[cmd_idx] <= CMD_STATE;
    end
  end
`else
  assign push = accept;
`endif

  // Pop only when the serializer is idle and something is waiting
  assign pop      = (state == S_IDLE) && !fifo_empty;
  assign fsm_done = (state == S_CMT_HOLD) && (cnt == 8'd0);

  assign fifo_empty     = (wr_ptr == rd_ptr);
  assign wr_ptr_nxt     = wr_ptr + (AW + 1)'(push);
  assign rd_ptr_nxt     = rd_ptr + (AW + 1)'(pop);
  assign fifo_empty_nxt = (wr_ptr_nxt == rd_ptr_nxt);
  assign fifo_full_nxt  = (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                          (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);

  // Whether the serializer will be outside IDLE after this edge
  always_comb begin
    fsm_active_nxt = 1'b1;
    if (state == S_IDLE) begin
      fsm_active_nxt = pop;
    end else if (fsm_done) begin
      fsm_active_nxt = 1'b0;
    end
  end

  // FIFO storage write; contents need no reset since pointers gate reads
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= cmd_entry;
    end
  end

  // FIFO pointers plus registered READY/BUSY derived from next-state values
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      CMD_READY <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      CMD_READY <= !fifo_full_nxt;
      BUSY      <= !fifo_empty_nxt || fsm_active_nxt;
    end
  end

  // Serializer FSM: each phase lasts DIV cycles, outputs change on phase entry
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      cnt      <= 8'd0;
      idx      <= 3'd0;
      sh_word  <= 7'd0;
      sh_state <= 1'b0;
      DAT      <= 1'b0;
      SK       <= 1'b0;
      STB      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          SK  <= 1'b0;
          STB <= 1'b0;
          if (pop) begin
            sh_word  <= head[7:1];
            sh_state <= head[0];
            idx      <= 3'd6;
            DAT      <= head[7];
            cnt      <= CNT_RELOAD;
            state    <= S_BIT_LO;
          end
        end
        S_BIT_LO: begin
          if (cnt == 8'd0) begin
            SK    <= 1'b1;
            cnt   <= CNT_RELOAD;
            state <= S_BIT_HI;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_BIT_HI: begin
          if (cnt == 8'd0) begin
            SK  <= 1'b0;
            cnt <= CNT_RELOAD;
            if (idx == 3'd0) begin
              DAT   <= sh_state;
              state <= S_CMT_SETUP;
            end else begin
              idx   <= idx - 3'd1;
              DAT   <= sh_word[idx - 3'd1];
              state <= S_BIT_LO;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_CMT_SETUP: begin
          if (cnt == 8'd0) begin
            STB   <= 1'b1;
            cnt   <= CNT_RELOAD;
            state <= S_CMT_STB;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_CMT_STB: begin
          if (cnt == 8'd0) begin
            STB   <= 1'b0;
            cnt   <= CNT_RELOAD;
            state <= S_CMT_HOLD;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_CMT_HOLD: begin
          if (cnt == 8'd0) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: begin
          SK    <= 1'b0;
          STB   <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zx_kbd_matrix_tx.sv
// tb_zx_kbd_matrix_tx
// Bench for zx_kbd_matrix_tx with DIV=2, FIFO_DEPTH=4.
// The serial line decoder rebuilds each frame from SK/STB edges.
// Decoded frames are compared against a queue of commands the bench expects to see.
module tb_zx_kbd_matrix_tx;

  localparam int DIV        = 2;
  localparam int DEPTH      = 4;
  localparam int CMD_CYCLES = 17 * DIV;
`ifdef ZX_KBD_SHADOW_EN
  localparam int SHADOW_SEQ_FRAMES = 1;
`else
  localparam int SHADOW_SEQ_FRAMES = 3;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] cmd_y = '0;
  logic [3:0] cmd_x = '0;
  logic       cmd_state = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       busy;
  logic       dat;
  logic       sk;
  logic       stb;
  logic [2:0] dbg_state;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  zx_kbd_matrix_tx #(.DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(clk), .RST(rst), .CMD_Y(cmd_y), .CMD_X(cmd_x), .CMD_STATE(cmd_state),
    .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .BUSY(busy), .DAT(dat),
    .SK(sk), .STB(stb), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #1_000_000;
    miscompares++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [7:0] exp_q[$];
  int frames_expected = 0;
  int frames_seen = 0;
  int sk_rises = 0;
`ifdef ZX_KBD_SHADOW_EN
  bit shadow_m[128];
`endif

  function automatic void model_reset();
    frames_expected -= exp_q.size();
    exp_q.delete();
`ifdef ZX_KBD_SHADOW_EN
    foreach (shadow_m[i]) shadow_m[i] = 1'b1;
`endif
  endfunction

  function automatic void model_accept(logic [2:0] y, logic [3:0] x, logic s);
`ifdef ZX_KBD_SHADOW_EN
    if (shadow_m[{y, x}] == s) return;
    shadow_m[{y, x}] = s;
`endif
    exp_q.push_back({y, x, s});
    frames_expected++;
  endfunction

  // ---------------- serial line monitor ----------------
  logic       p_sk = 1'b0, p_stb = 1'b0, p_dat = 1'b0;
  logic [6:0] bits = '0;
  int         nbits = 0;
  int         sk_start = 0, stb_start = 0, frame_first_sk = 0;
  logic [6:0] last_word = '0;
  logic       last_st = 1'b0;
  logic [7:0] e;
  int         first_sk_q[$];

  always @(negedge clk) begin
    if (rst) begin
      nbits = 0;
      p_sk = 1'b0; p_stb = 1'b0; p_dat = 1'b0;
    end else begin
      chk("sk_stb_overlap", {31'd0, sk && stb}, 0);
      if (sk || stb) chk("dat_stable", {31'd0, dat}, {31'd0, p_dat});
      if (sk && !p_sk) begin
        if (nbits == 0) frame_first_sk = cyc;
        bits = {bits[5:0], dat};
        nbits++;
        sk_rises++;
        sk_start = cyc;
      end
      if (!sk && p_sk) chk("sk_width", cyc - sk_start, DIV);
      if (stb && !p_stb) begin
        stb_start = cyc;
        frames_seen++;
        chk("frame_bits", nbits, 7);
        first_sk_q.push_back(frame_first_sk);
        last_word = bits;
        last_st = dat;
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("frame_word", {25'd0, bits}, {25'd0, e[7:1]});
          chk("frame_state", {31'd0, dat}, {31'd0, e[0]});
        end
        nbits = 0;
      end
      if (!stb && p_stb) chk("stb_width", cyc - stb_start, DIV);
      p_sk = sk; p_stb = stb; p_dat = dat;
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send(input logic [2:0] y, input logic [3:0] x, input logic s,
                      output int acc_cyc);
    int n = 0;
    cmd_y = y; cmd_x = x; cmd_state = s; cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("accept_timeout", 0, 1);
    else model_accept(y, x, s);
    acc_cyc = cyc;
    @(negedge clk);
  endtask

  task automatic wait_idle(input int budget, output int busy_cycles);
    int n = 0;
    while (busy === 1'b1 && n < budget) begin
      n++;
      @(negedge clk);
    end
    if (n >= budget) chk("idle_timeout", 0, 1);
    busy_cycles = n;
  endtask

  task automatic check_quiescent(input string name);
    chk({name, "_exp_q_empty"}, exp_q.size(), 0);
    chk({name, "_frame_count"}, frames_seen, frames_expected);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [2:0] y;
    logic [3:0] x;
    logic       st;
    logic [6:0] exp_word;
  } vec_t;

  vec_t tab[6];

  initial begin
    int acc, bc, fs, rs, r, n, sz;
    int acc_b[6];
    logic ps;

    tab[0] = '{y: 3'd1, x: 4'd3,  st: 1'b0, exp_word: 7'b0010011};
    tab[1] = '{y: 3'd5, x: 4'd8,  st: 1'b0, exp_word: 7'b1011000};
    tab[2] = '{y: 3'd7, x: 4'd15, st: 1'b0, exp_word: 7'b1111111};
    tab[3] = '{y: 3'd0, x: 4'd0,  st: 1'b0, exp_word: 7'b0000000};
    tab[4] = '{y: 3'd1, x: 4'd3,  st: 1'b1, exp_word: 7'b0010011};
    tab[5] = '{y: 3'd3, x: 4'd9,  st: 1'b0, exp_word: 7'b0111001};

    // Reset values
    rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_dat", {31'd0, dat}, 0);
    chk("reset_sk", {31'd0, sk}, 0);
    chk("reset_stb", {31'd0, stb}, 0);
    chk("reset_busy", {31'd0, busy}, 0);
    chk("reset_ready", {31'd0, cmd_ready}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_release", {31'd0, cmd_ready}, 1);
    chk("busy_after_release", {31'd0, busy}, 0);

    // Single commands from idle
    for (int i = 0; i < 6; i++) begin
      send(tab[i].y, tab[i].x, tab[i].st, acc);
      cmd_valid = 1'b0;
      wait_idle(200, bc);
      chk("busy_cycles", bc, CMD_CYCLES + 1);
      chk("first_sk_latency", first_sk_q[$] - acc, 2 + DIV);
      chk("word", {25'd0, last_word}, {25'd0, tab[i].exp_word});
      chk("dat_at_stb", {31'd0, last_st}, {31'd0, tab[i].st});
      repeat (2) @(negedge clk);
    end
    check_quiescent("directed");

    // Held VALID with six commands against a 4-deep FIFO
    for (int i = 0; i < 6; i++) send(3'(i), 4'd4, 1'b0, acc_b[i]);
    cmd_valid = 1'b0;
    for (int i = 1; i < 5; i++) chk("burst_accept", acc_b[i] - acc_b[0], i);
    chk("full_accept", acc_b[5] - acc_b[0], CMD_CYCLES + 3);
    wait_idle(600, bc);
    sz = first_sk_q.size();
    if (sz < 6) chk("burst_frames", sz, 6);
    else for (int k = 1; k < 6; k++)
      chk("burst_spacing", first_sk_q[sz - 6 + k] - first_sk_q[sz - 7 + k], CMD_CYCLES + 1);
    check_quiescent("burst");
    repeat (2) @(negedge clk);

    // Reset during BIT_HI of the 4th bit with two commands queued
    send(3'd6, 4'd13, 1'b0, acc);
    send(3'd6, 4'd14, 1'b0, acc);
    send(3'd6, 4'd12, 1'b0, acc);
    cmd_valid = 1'b0;
    r = 0; n = 0; ps = sk;
    while (r < 4 && n < 300) begin
      @(negedge clk);
      if (sk && !ps) r++;
      ps = sk;
      n++;
    end
    chk("pre_reset_sk", {31'd0, sk}, 1);
    chk("pre_reset_dat", {31'd0, dat}, 1);
    rst = 1'b1;
    #1;
    chk("midrst_dat", {31'd0, dat}, 0);
    chk("midrst_sk", {31'd0, sk}, 0);
    chk("midrst_stb", {31'd0, stb}, 0);
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_ready", {31'd0, cmd_ready}, 0);
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    fs = frames_seen; rs = sk_rises;
    @(negedge clk);
    chk("midrst_ready_release", {31'd0, cmd_ready}, 1);
    repeat (60) @(negedge clk);
    chk("midrst_no_frame", frames_seen, fs);
    chk("midrst_no_sk", sk_rises, rs);
    send(3'd2, 4'd1, 1'b0, acc);
    cmd_valid = 1'b0;
    wait_idle(200, bc);
    chk("midrst_clean_word", {25'd0, last_word}, {25'd0, 7'b0100001});
    check_quiescent("midrst");

    // Redundant-command sequence on switch Y=2,X=2 right after reset
    fs = frames_seen; rs = sk_rises;
    send(3'd2, 4'd2, 1'b1, acc);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    wait_idle(200, bc);
    send(3'd2, 4'd2, 1'b0, acc);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    wait_idle(200, bc);
    send(3'd2, 4'd2, 1'b0, acc);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    wait_idle(200, bc);
    chk("shadow_seq_frames", frames_seen - fs, SHADOW_SEQ_FRAMES);
    chk("shadow_seq_sk", sk_rises - rs, 7 * SHADOW_SEQ_FRAMES);
    check_quiescent("shadow_seq");

    // Randomized commands with random gaps
    for (int i = 0; i < 40; i++) begin
      cmd_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), acc);
    end
    cmd_valid = 1'b0;
    wait_idle(3000, bc);
    repeat (3) @(negedge clk);
    check_quiescent("random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
